// File: rtl/voice_allocator.sv
// ============================================================================
// voice_allocator : maps keyboard press/release edges onto oscillator voices,
//                   stealing the oldest voice when every voice is busy.
// Revision: 1.0
// ============================================================================
`default_nettype none

module voice_allocator #(
  parameter int NUM_VOICES           = 4,
  parameter int NUM_KEYS             = 13,
  parameter int SYNTH_PHASE_ACC_BITS = 24
) (
  input  logic                                       clk_in,
  input  logic                                       rst_in,
  input  logic [NUM_KEYS-1:0]                        keys_in,
  output logic [NUM_VOICES*SYNTH_PHASE_ACC_BITS-1:0] phase_incr_out,
  output logic [NUM_VOICES-1:0]                      voice_active_out,
  output logic [NUM_VOICES*4-1:0]                    voice_key_out,
  output logic [NUM_VOICES-1:0]                      trigger_out
);

  localparam int AW = $clog2(NUM_VOICES);
  localparam int PW = SYNTH_PHASE_ACC_BITS;

  typedef enum logic [0:0] {
    SCAN  = 1'b0,
    APPLY = 1'b1
  } state_t;

  function automatic logic [PW-1:0] incr_lookup(input logic [3:0] key);
    logic [PW-1:0] val;
    case (key)
      4'd0:    val = PW'(20'h0E107);
      4'd1:    val = PW'(20'h0D465);
      4'd2:    val = PW'(20'h0C87A);
      4'd3:    val = PW'(20'h0BD3A);
      4'd4:    val = PW'(20'h0B29A);
      4'd5:    val = PW'(20'h0A894);
      4'd6:    val = PW'(20'h09F1E);
      4'd7:    val = PW'(20'h09630);
      4'd8:    val = PW'(20'h08DC1);
      4'd9:    val = PW'(20'h085CD);
      4'd10:   val = PW'(20'h07E4A);
      4'd11:   val = PW'(20'h07734);
      4'd12:   val = PW'(20'h07084);
      default: val = '0;
    endcase
    return val;
  endfunction

  state_t                 state_q, state_d;
  logic [NUM_KEYS-1:0]    key_ack_q, key_ack_d;
  logic [3:0]             ev_key_q, ev_key_d;
  logic                   ev_press_q, ev_press_d;
  logic [NUM_VOICES-1:0]  active_q, active_d;
  logic [NUM_VOICES-1:0]  trig_q, trig_d;
  logic [3:0]             vkey_q [NUM_VOICES];
  logic [3:0]             vkey_d [NUM_VOICES];
  logic [PW-1:0]          incr_q [NUM_VOICES];
  logic [PW-1:0]          incr_d [NUM_VOICES];
  logic [AW-1:0]          age_q  [NUM_VOICES];
  logic [AW-1:0]          age_d  [NUM_VOICES];

  logic [NUM_KEYS-1:0]    diff;
  logic [3:0]             scan_key;
  logic [AW-1:0]          target;
  logic [AW-1:0]          target_age;
  logic                   found_free;

  always_comb begin
    state_d    = state_q;
    key_ack_d  = key_ack_q;
    ev_key_d   = ev_key_q;
    ev_press_d = ev_press_q;
    active_d   = active_q;
    trig_d     = '0;
    vkey_d     = vkey_q;
    incr_d     = incr_q;
    age_d      = age_q;
    target     = '0;
    target_age = '0;
    found_free = 1'b0;

    diff     = keys_in ^ key_ack_q;
    scan_key = '0;
    for (int i = NUM_KEYS-1; i >= 0; i--) begin
      if (diff[i]) scan_key = 4'(i);
    end

    case (state_q)
      SCAN: begin
        if (|diff) begin
          ev_key_d   = scan_key;
          ev_press_d = keys_in[scan_key];
          state_d    = APPLY;
        end
      end
      APPLY: begin
        state_d = SCAN;
        if (ev_press_q) begin
          for (int i = NUM_VOICES-1; i >= 0; i--) begin
            if (!active_q[i]) begin
              target     = AW'(i);
              found_free = 1'b1;
            end
          end
          // No free voice: steal whichever voice carries the oldest rank
          if (!found_free) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (age_q[i] == AW'(NUM_VOICES-1)) target = AW'(i);
            end
          end
          target_age = age_q[target];
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (age_q[i] < target_age) age_d[i] = age_q[i] + 1'b1;
          end
          age_d[target]       = '0;
          active_d[target]    = 1'b1;
          vkey_d[target]      = ev_key_q;
          incr_d[target]      = incr_lookup(ev_key_q);
          trig_d[target]      = 1'b1;
          key_ack_d[ev_key_q] = 1'b1;
        end else begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (active_q[i] && (vkey_q[i] == ev_key_q)) active_d[i] = 1'b0;
          end
          key_ack_d[ev_key_q] = 1'b0;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= SCAN;
      key_ack_q  <= '0;
      ev_key_q   <= '0;
      ev_press_q <= 1'b0;
      active_q   <= '0;
      trig_q     <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        vkey_q[i] <= '0;
        incr_q[i] <= '0;
        age_q[i]  <= AW'(NUM_VOICES-1-i);
      end
    end else begin
      state_q    <= state_d;
      key_ack_q  <= key_ack_d;
      ev_key_q   <= ev_key_d;
      ev_press_q <= ev_press_d;
      active_q   <= active_d;
      trig_q     <= trig_d;
      vkey_q     <= vkey_d;
      incr_q     <= incr_d;
      age_q      <= age_d;
    end
  end

  generate
    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice_out
      assign phase_incr_out[v*PW +: PW] = incr_q[v];
      assign voice_key_out[v*4 +: 4]    = vkey_q[v];
    end
  endgenerate

  assign voice_active_out = active_q;
  assign trigger_out      = trig_q;

endmodule

`default_nettype wire

// File: tb/tb_voice_allocator.sv
// ============================================================================
// tb_voice_allocator : directed self-checking bench for voice_allocator.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_voice_allocator;

  localparam int NV = 4;

  logic          clk_in;
  logic          rst_in;
  logic [12:0]   keys_in;
  logic [NV*24-1:0] phase_incr_out;
  logic [NV-1:0] voice_active_out;
  logic [NV*4-1:0] voice_key_out;
  logic [NV-1:0] trigger_out;

  int tests_run;
  int tests_failed;

  voice_allocator #(.NUM_VOICES(NV), .NUM_KEYS(13), .SYNTH_PHASE_ACC_BITS(24)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .keys_in          (keys_in),
    .phase_incr_out   (phase_incr_out),
    .voice_active_out (voice_active_out),
    .voice_key_out    (voice_key_out),
    .trigger_out      (trigger_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  function automatic logic [23:0] incr(input int v);
    return phase_incr_out[v*24 +: 24];
  endfunction

  function automatic logic [3:0] vkey(input int v);
    return voice_key_out[v*4 +: 4];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in  = 1'b1;
    keys_in = '0;
    tick(2);
    rst_in  = 1'b0;
  endtask

  task automatic test_reset();
    rst_in  = 1'b1;
    keys_in = '0;
    tick(2);
    tests_run++;
    if ({phase_incr_out, voice_active_out, voice_key_out, trigger_out} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got act=%b trig=%b expected all zero", voice_active_out, trigger_out);
    end
    rst_in = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      tests_run++;
      if ({phase_incr_out, voice_active_out, voice_key_out, trigger_out} !== '0) begin
        tests_failed++;
        $display("FAIL idle_after_reset cycle %0d: got act=%b trig=%b expected all zero", c, voice_active_out, trigger_out);
      end
    end
  endtask

  task automatic test_single_key();
    do_reset();
    keys_in = 13'(1 << 7);
    tick(1);
    tests_run++;
    if (trigger_out !== 4'b0000 || voice_active_out !== 4'b0000) begin
      tests_failed++;
      $display("FAIL single_early: got act=%b trig=%b expected 0000 0000", voice_active_out, trigger_out);
    end
    tick(1);
    tests_run++;
    if (voice_active_out !== 4'b0001 || incr(0) !== 24'h009630 || vkey(0) !== 4'd7 || trigger_out !== 4'b0001) begin
      tests_failed++;
      $display("FAIL single_press: got act=%b incr0=%h key0=%0d trig=%b expected 0001 009630 7 0001",
               voice_active_out, incr(0), vkey(0), trigger_out);
    end
    tick(1);
    tests_run++;
    if (trigger_out !== 4'b0000) begin
      tests_failed++;
      $display("FAIL single_trig_width: got trig=%b expected 0000", trigger_out);
    end
    keys_in = '0;
    tick(2);
    tests_run++;
    if (voice_active_out !== 4'b0000 || incr(0) !== 24'h009630 || vkey(0) !== 4'd7 || trigger_out !== 4'b0000) begin
      tests_failed++;
      $display("FAIL single_release: got act=%b incr0=%h key0=%0d trig=%b expected 0000 009630 7 0000",
               voice_active_out, incr(0), vkey(0), trigger_out);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    keys_in = 13'b1_0000_0000_1001;
    tick(2);
    tests_run++;
    if (voice_active_out !== 4'b0001 || vkey(0) !== 4'd0 || incr(0) !== 24'h00E107 || trigger_out !== 4'b0001) begin
      tests_failed++;
      $display("FAIL simul_key0: got act=%b key0=%0d incr0=%h trig=%b expected 0001 0 00e107 0001",
               voice_active_out, vkey(0), incr(0), trigger_out);
    end
    tick(2);
    tests_run++;
    if (voice_active_out !== 4'b0011 || vkey(1) !== 4'd3 || incr(1) !== 24'h00BD3A || trigger_out !== 4'b0010) begin
      tests_failed++;
      $display("FAIL simul_key3: got act=%b key1=%0d incr1=%h trig=%b expected 0011 3 00bd3a 0010",
               voice_active_out, vkey(1), incr(1), trigger_out);
    end
    tick(2);
    tests_run++;
    if (voice_active_out !== 4'b0111 || vkey(2) !== 4'd12 || incr(2) !== 24'h007084 || trigger_out !== 4'b0100) begin
      tests_failed++;
      $display("FAIL simul_key12: got act=%b key2=%0d incr2=%h trig=%b expected 0111 12 007084 0100",
               voice_active_out, vkey(2), incr(2), trigger_out);
    end
    tick(2);
    tests_run++;
    if (voice_active_out !== 4'b0111 || trigger_out !== 4'b0000) begin
      tests_failed++;
      $display("FAIL simul_settle: got act=%b trig=%b expected 0111 0000", voice_active_out, trigger_out);
    end
  endtask

  task automatic test_steal();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      keys_in = keys_in | 13'(1 << k);
      tick(2);
    end
    tests_run++;
    if (voice_active_out !== 4'b1111 || voice_key_out !== 16'h4321) begin
      tests_failed++;
      $display("FAIL steal_fill: got act=%b keys=%h expected 1111 4321", voice_active_out, voice_key_out);
    end
    keys_in = keys_in | 13'(1 << 5);
    tick(2);
    tests_run++;
    if (trigger_out !== 4'b0001 || vkey(0) !== 4'd5 || incr(0) !== 24'h00A894 || voice_active_out !== 4'b1111) begin
      tests_failed++;
      $display("FAIL steal_oldest: got trig=%b key0=%0d incr0=%h act=%b expected 0001 5 00a894 1111",
               trigger_out, vkey(0), incr(0), voice_active_out);
    end
    keys_in = keys_in & ~13'(1 << 1);
    tick(2);
    tests_run++;
    if (voice_active_out !== 4'b1111 || voice_key_out !== 16'h4325 || trigger_out !== 4'b0000) begin
      tests_failed++;
      $display("FAIL steal_release_orphan: got act=%b keys=%h trig=%b expected 1111 4325 0000",
               voice_active_out, voice_key_out, trigger_out);
    end
    keys_in = keys_in | 13'(1 << 6);
    tick(2);
    tests_run++;
    if (trigger_out !== 4'b0010 || vkey(1) !== 4'd6 || incr(1) !== 24'h009F1E) begin
      tests_failed++;
      $display("FAIL steal_second: got trig=%b key1=%0d incr1=%h expected 0010 6 009f1e",
               trigger_out, vkey(1), incr(1));
    end
  endtask

  task automatic test_free_reuse();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      keys_in = keys_in | 13'(1 << k);
      tick(2);
    end
    keys_in = keys_in & ~13'(1 << 2);
    tick(2);
    tests_run++;
    if (voice_active_out !== 4'b1101 || vkey(1) !== 4'd2) begin
      tests_failed++;
      $display("FAIL reuse_release: got act=%b key1=%0d expected 1101 2", voice_active_out, vkey(1));
    end
    keys_in = keys_in | 13'(1 << 9);
    tick(2);
    tests_run++;
    if (trigger_out !== 4'b0010 || vkey(1) !== 4'd9 || incr(1) !== 24'h0085CD || voice_active_out !== 4'b1111) begin
      tests_failed++;
      $display("FAIL reuse_free_voice: got trig=%b key1=%0d incr1=%h act=%b expected 0010 9 0085cd 1111",
               trigger_out, vkey(1), incr(1), voice_active_out);
    end
    keys_in = keys_in | 13'(1 << 10);
    tick(2);
    tests_run++;
    if (trigger_out !== 4'b0001 || vkey(0) !== 4'd10 || incr(0) !== 24'h007E4A) begin
      tests_failed++;
      $display("FAIL reuse_steal_oldest: got trig=%b key0=%0d incr0=%h expected 0001 10 007e4a",
               trigger_out, vkey(0), incr(0));
    end
  endtask

  task automatic test_reset_mid_apply();
    do_reset();
    keys_in = 13'(1 << 0);
    tick(2);
    keys_in = 13'(1 << 0) | 13'(1 << 6);
    tick(1);
    rst_in = 1'b1;
    #1;
    tests_run++;
    if ({phase_incr_out, voice_active_out, voice_key_out, trigger_out} !== '0) begin
      tests_failed++;
      $display("FAIL midapply_reset: got act=%b trig=%b key0=%0d expected all zero",
               voice_active_out, trigger_out, vkey(0));
    end
    keys_in = 13'(1 << 6);
    tick(2);
    tests_run++;
    if (trigger_out !== 4'b0000 || voice_active_out !== 4'b0000) begin
      tests_failed++;
      $display("FAIL midapply_hold: got act=%b trig=%b expected 0000 0000", voice_active_out, trigger_out);
    end
    rst_in = 1'b0;
    tick(2);
    tests_run++;
    if (trigger_out !== 4'b0001 || voice_active_out !== 4'b0001 || vkey(0) !== 4'd6 || incr(0) !== 24'h009F1E) begin
      tests_failed++;
      $display("FAIL midapply_realloc: got trig=%b act=%b key0=%0d incr0=%h expected 0001 0001 6 009f1e",
               trigger_out, voice_active_out, vkey(0), incr(0));
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_in       = 1'b1;
    keys_in      = '0;
    test_reset();
    test_single_key();
    test_simultaneous();
    test_steal();
    test_free_reuse();
    test_reset_mid_apply();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
